multicycle_fetch_control: RTL

//   Multicycle control FSM and program counter for the instruction-memory datapath.

---
 rtl/multicycle_fetch_control.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multicycle_fetch_control.sv
// rtl/multicycle_fetch_control.sv - multicycle control FSM, program counter and retire counter
// Walks FETCH/DECODE/EXEC/MEM/WB per opcode; strobes are registered Moore decodes of the next state.
module multicycle_fetch_control #(
    parameter int                  PC_WIDTH    = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  COUNT_WIDTH = 16
) (
    input  logic                   in_clock,
    input  logic                   in_reset_n,
    input  logic                   in_enable,
    input  logic [31:0]            in_instruction,
    input  logic                   in_alu_zero,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   out_ir_write,
    output logic                   out_reg_write,
    output logic                   out_reg_dst,
    output logic                   out_alu_src,
    output logic [1:0]             out_alu_op,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic [3:0]             out_state,
    output logic                   out_halt,
    output logic [COUNT_WIDTH-1:0] out_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // Control word: {ir_write, reg_write, reg_dst, alu_src, alu_op[1:0], mem_read, mem_write, mem_to_reg, halt}
    localparam int CTL_W = 10;

    state_t                   r_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [COUNT_WIDTH-1:0]   r_retired;
    logic                     r_is_load;
    logic [CTL_W-1:0]         r_ctl;

    state_t                   w_next_state;
    logic [5:0]               w_opcode;
    logic [PC_WIDTH-1:0]      w_imm;
    logic                     w_retire;
    logic                     w_unused;

    assign w_opcode = in_instruction[31:26];
    assign w_imm    = in_instruction[PC_WIDTH-1:0];
    assign w_unused = ^in_instruction[25:PC_WIDTH];

    function automatic logic [CTL_W-1:0] ctl_for(input state_t s);
        logic [CTL_W-1:0] c;
        c = '0;
        case (s)
            S_FETCH:  c = 10'b1_0_0_0_00_0_0_0_0;
            S_EXEC_R: c = 10'b0_0_0_0_10_0_0_0_0;
            S_WB_R:   c = 10'b0_1_1_0_00_0_0_0_0;
            S_ADDR:   c = 10'b0_0_0_1_00_0_0_0_0;
            S_MEM_RD: c = 10'b0_0_0_1_00_1_0_0_0;
            S_WB_MEM: c = 10'b0_1_0_0_00_0_0_1_0;
            S_MEM_WR: c = 10'b0_0_0_1_00_0_1_0_0;
            S_BRANCH: c = 10'b0_0_0_0_01_0_0_0_0;
            S_HALT:   c = 10'b0_0_0_0_00_0_0_0_1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next_state = r_state;
        if (in_enable || r_state == S_HALT) begin
            case (r_state)
                S_FETCH:  w_next_state = S_DECODE;
                S_DECODE: begin
                    case (w_opcode)
                        OP_R:         w_next_state = S_EXEC_R;
                        OP_LW, OP_SW: w_next_state = S_ADDR;
                        OP_BEQ:       w_next_state = S_BRANCH;
                        OP_J:         w_next_state = S_JUMP;
                        default:      w_next_state = S_HALT;
                    endcase
                end
                S_EXEC_R: w_next_state = S_WB_R;
                S_ADDR:   w_next_state = r_is_load ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: w_next_state = S_WB_MEM;
                S_WB_R, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP:
                          w_next_state = S_FETCH;
                S_HALT:   w_next_state = S_HALT;
                default:  w_next_state = S_HALT;
            endcase
        end
    end

    assign w_retire = in_enable &&
                      (r_state == S_WB_R   || r_state == S_WB_MEM || r_state == S_MEM_WR ||
                       r_state == S_BRANCH || r_state == S_JUMP);

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_retired <= '0;
            r_is_load <= 1'b0;
            r_ctl     <= ctl_for(S_FETCH);
        end else begin
            r_state <= w_next_state;
            r_ctl   <= ctl_for(w_next_state);
            if (w_retire)
                r_retired <= r_retired + COUNT_WIDTH'(1);
            if (in_enable) begin
                case (r_state)
                    S_FETCH:  r_pc <= r_pc + PC_WIDTH'(1);
                    S_DECODE: r_is_load <= (w_opcode == OP_LW);
                    // pc already points past the branch, so the offset is relative to pc+1
                    S_BRANCH: if (in_alu_zero) r_pc <= r_pc + w_imm;
                    S_JUMP:   r_pc <= w_imm;
                    default:  ;
                endcase
            end
        end
    end

    assign out_pc         = r_pc;
    assign out_state      = r_state;
    assign out_retired    = r_retired;
    assign out_ir_write   = r_ctl[9];
    assign out_reg_write  = r_ctl[8];
    assign out_reg_dst    = r_ctl[7];
    assign out_alu_src    = r_ctl[6];
    assign out_alu_op     = r_ctl[5:4];
    assign out_mem_read   = r_ctl[3];
    assign out_mem_write  = r_ctl[2];
    assign out_mem_to_reg = r_ctl[1];
    assign out_halt       = r_ctl[0];

endmodule
